// File: rtl/result_tx_framer.sv
// result_tx_framer: buffers one frame of (ch0, ch1) result pairs from the last
// pipeline stage, then streams it to the host as bytes over valid/ready.
// Frame: HEADER, DEPTH[7:0], ch0/ch1 interleaved per pair, optional checksum.
// Optional feature macro: TX_CHECKSUM_EN (appends a negated mod-256 data sum).
module result_tx_framer #(
    parameter int                DEPTH  = 36,
    parameter int                DATA_W = 8,
    parameter logic [DATA_W-1:0] HEADER = 'hA5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data_0,
    input  logic [DATA_W-1:0] in_data_1,
    input  logic              tx_ready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    output logic              busy,
    output logic              overflow,
    output logic              frame_done
);

    // Pointer width covers DEPTH entries; a 1-entry frame still needs 1 bit.
    localparam int                AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]     LAST_IDX   = AW'(DEPTH - 1);
    localparam logic [DATA_W-1:0] COUNT_BYTE = DATA_W'(DEPTH % 256);

`ifdef TX_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_FILL,
        ST_HEADER,
        ST_COUNT,
        ST_DATA,
        ST_CSUM
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_FILL,
        ST_HEADER,
        ST_COUNT,
        ST_DATA
    } state_t;
`endif

    state_t            state_q;
    state_t            state_d;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              lane;        // 0: ch0 byte next, 1: ch1 byte next
    logic              capture;     // pair is accepted into the buffer
    logic              xfer;        // a byte moves to the host this edge
    logic              last_xfer;   // the byte moving now ends the frame
    logic              frame_done_q;
    logic              overflow_q;
    logic [DATA_W-1:0] mem0 [DEPTH];
    logic [DATA_W-1:0] mem1 [DEPTH];
`ifdef TX_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    assign capture    = (state_q == ST_FILL) && in_valid;
    assign overflow   = overflow_q;
    assign frame_done = frame_done_q;

    // State register; reset aborts any frame in flight and returns to FILL.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and byte presentation; outputs depend only on the
    // registered state and pointers, so they hold steady through a stall.
    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves a
        // variable unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        tx_valid  = 1'b0;
        tx_data   = '0;
        busy      = 1'b0;
        last_xfer = 1'b0;
        case (state_q)
            ST_FILL: begin
                if (capture && (wr_ptr == LAST_IDX)) begin
                    state_d = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    state_d = ST_COUNT;
                end
            end
            ST_COUNT: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = COUNT_BYTE;
                if (tx_ready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = lane ? mem1[rd_ptr] : mem0[rd_ptr];
                if (tx_ready && lane && (rd_ptr == LAST_IDX)) begin
`ifdef TX_CHECKSUM_EN
                    state_d = ST_CSUM;
`else
                    state_d   = ST_FILL;
                    last_xfer = 1'b1;
`endif
                end
            end
`ifdef TX_CHECKSUM_EN
            ST_CSUM: begin
                tx_valid = 1'b1;
                busy     = 1'b1;
                tx_data  = -acc;
                if (tx_ready) begin
                    state_d   = ST_FILL;
                    last_xfer = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    assign xfer = tx_valid && tx_ready;

    // Write/read pointers and lane select; both pointers are back at 0 when
    // the frame ends, so the next fill and transmit start from entry 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lane   <= 1'b0;
        end else begin
            if (capture) begin
                wr_ptr <= (wr_ptr == LAST_IDX) ? '0 : wr_ptr + 1'b1;
            end
            if ((state_q == ST_DATA) && xfer) begin
                lane <= ~lane;
                if (lane) begin
                    rd_ptr <= (rd_ptr == LAST_IDX) ? '0 : rd_ptr + 1'b1;
                end
            end
        end
    end

    // Frame buffer write port for both channels.
    always_ff @(posedge clk) begin
        // NOTE: the buffer has no reset; every entry is written during FILL
        // before it is read, so clearing it would only cost logic.
        if (capture) begin
            mem0[wr_ptr] <= in_data_0;
            mem1[wr_ptr] <= in_data_1;
        end
    end

    // Status flags: sticky overflow for pairs arriving outside FILL, and a
    // one-cycle done pulse following the final byte of a frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q   <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            if (in_valid && (state_q != ST_FILL)) begin
                overflow_q <= 1'b1;
            end
            frame_done_q <= last_xfer;
        end
    end

`ifdef TX_CHECKSUM_EN
    // Running mod-2^DATA_W sum of data bytes; cleared on entry to HEADER.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if ((state_q == ST_FILL) && (state_d == ST_HEADER)) begin
            acc <= '0;
        end else if ((state_q == ST_DATA) && xfer) begin
            acc <= acc + tx_data;
        end
    end
`endif

endmodule

// File: tb/tb_result_tx_framer.sv
// tb_result_tx_framer: randomized scoreboard bench for result_tx_framer.
// Stimulus pushes each frame's expected byte list; a monitor pops on every
// accepted byte and also checks stall stability, frame_done and overflow.
module tb_result_tx_framer;

    localparam int         DEPTH  = 36;
    localparam int         DATA_W = 8;
    localparam logic [7:0] HDR    = 8'hA5;
`ifdef TX_CHECKSUM_EN
    localparam int FRAME_LEN = 2 + 2 * DEPTH + 1;
`else
    localparam int FRAME_LEN = 2 + 2 * DEPTH;
`endif

    typedef struct {
        logic [7:0] data;
        bit         last;
    } exp_t;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic [DATA_W-1:0] in_data_0;
    logic [DATA_W-1:0] in_data_1;
    logic              tx_ready;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    logic              busy;
    logic              overflow;
    logic              frame_done;

    exp_t       exp_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         frames_done = 0;
    int         frame_bytes = 0;
    int         ready_mode = 0;   // 0: always ready, 1: 1-high/3-low, 2: random
    bit         ovf_exp = 1'b0;
    bit         done_pend = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] stall_data = '0;

    result_tx_framer #(
        .DEPTH (DEPTH),
        .DATA_W(DATA_W),
        .HEADER(HDR)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data_0 (in_data_0),
        .in_data_1 (in_data_1),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .busy      (busy),
        .overflow  (overflow),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Host-side ready pattern, updated just after each rising edge.
    initial begin
        int cyc = 0;
        tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                0:       tx_ready = 1'b1;
                1:       tx_ready = (cyc % 4 == 0);
                default: tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
            done_pend   = 1'b0;
            stalled     = 1'b0;
            frame_bytes = 0;
        end else begin
            if (done_pend || frame_done) begin
                check("frame_done", frame_done, done_pend);
            end
            if (frame_done) begin
                check("frame_len", frame_bytes, FRAME_LEN);
                check("overflow", overflow, ovf_exp);
                check("idle_after_frame", tx_valid, 0);
                frames_done++;
                frame_bytes = 0;
            end
            done_pend = 1'b0;
            if (stalled) begin
                check("stall_valid", tx_valid, 1);
                check("stall_data", tx_data, stall_data);
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_byte: got 0x%0h expected no byte at %0t", tx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_data, e.data);
                    check("busy", busy, 1);
                    done_pend = e.last;
                end
                frame_bytes++;
            end
            stalled    = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    // Reference frame: header, pair count, pairs interleaved, then (if built)
    // the byte that brings the data sum to zero mod 256.
    task automatic fill(input int pat, input bit gaps);
        logic [7:0]  d0, d1;
        int unsigned sum = 0;
        exp_q.push_back('{HDR, 1'b0});
        exp_q.push_back('{8'(DEPTH), 1'b0});
        for (int i = 0; i < DEPTH; i++) begin
            case (pat)
                0:       begin d0 = 8'(i); d1 = 8'(i + 100); end
                1:       begin d0 = 8'($urandom); d1 = 8'($urandom); end
                default: begin d0 = 8'hFF; d1 = 8'hFF; end
            endcase
            sum += d0 + d1;
            exp_q.push_back('{d0, 1'b0});
`ifdef TX_CHECKSUM_EN
            exp_q.push_back('{d1, 1'b0});
`else
            exp_q.push_back('{d1, (i == DEPTH - 1)});
`endif
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                    in_valid = 1'b0;
                end
            end
            @(posedge clk);
            #1;
            in_valid  = 1'b1;
            in_data_0 = d0;
            in_data_1 = d1;
        end
`ifdef TX_CHECKSUM_EN
        exp_q.push_back('{8'((256 - (sum % 256)) % 256), 1'b1});
`endif
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_frames(input int target);
        int n = 0;
        while (frames_done < target && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (frames_done < target) begin
            n_cmp++;
            n_err++;
            $display("FAIL frame_timeout: got %0d frames expected %0d", frames_done, target);
        end
    endtask

    // One stray pair while the frame is being sent; it must be dropped.
    task automatic stray_pulse();
        int n = 0;
        while (!(busy && frame_bytes >= 1 && exp_q.size() > 4) && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b1;
        in_data_0 = 8'h5A;
        in_data_1 = 8'hC3;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ovf_exp  = 1'b1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_tx_valid"}, tx_valid, 0);
        check({tag, "_tx_data"}, tx_data, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_overflow"}, overflow, 0);
        check({tag, "_frame_done"}, frame_done, 0);
    endtask

    initial begin
        int f;
        int n;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data_0 = '0;
        in_data_1 = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        #1;
        check_idle("reset");

        // Ramp pattern, host always ready.
        ready_mode = 0;
        f = frames_done;
        fill(0, 1'b0);
        wait_frames(f + 1);

        // Same frame under a 1-high/3-low ready pattern.
        ready_mode = 1;
        fill(0, 1'b0);
        wait_frames(f + 2);

        // Random pairs with input gaps, plus a pair arriving while busy.
        fill(1, 1'b1);
        stray_pulse();
        wait_frames(f + 3);

        // Reset after the 10th data byte, then a fresh complete frame.
        ready_mode = 2;
        fill(1, 1'b1);
        n = 0;
        while (frame_bytes < 12 && n < 3000) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reached_10_data_bytes", (frame_bytes >= 12), 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        ovf_exp = 1'b0;
        @(negedge clk);
        #1;
        check_idle("midframe_reset");
        f = frames_done;
        fill(0, 1'b1);
        wait_frames(f + 1);

        // Back-to-back frames: second fill starts right after frame_done.
        ready_mode = 0;
        fill(1, 1'b0);
        wait_frames(f + 2);
        fill(1, 1'b0);
        wait_frames(f + 3);

        // All-ones frame under random backpressure (checksum corner).
        ready_mode = 2;
        fill(2, 1'b0);
        wait_frames(f + 4);

        // A few more random frames.
        for (int k = 0; k < 3; k++) begin
            fill(1, 1'b1);
            wait_frames(f + 5 + k);
        end

        repeat (4) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_busy", busy, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
